// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared widths, request type and helpers for the register-file
//               write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [REG_DW-1:0] wdata;
    } rf_wreq_t;

    // One-hot decode of a register index into a 32-bit mask.
    function automatic logic [31:0] onehot32(input logic [REG_AW-1:0] idx);
        onehot32 = 32'd1 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_fifo
// Description : DEPTH-entry circular buffer of register-file write requests.
//               Exposes per-entry valid/address so the owner can build the
//               pending-destination mask.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  rf_wreq_t                  pushData,
    input  logic                      pop,
    output rf_wreq_t                  head,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          entValid,
    output logic [DEPTH*REG_AW-1:0]   entAddr
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH) + 1;

    rf_wreq_t          r_mem [DEPTH];
    logic [c_PW-1:0]   r_wrPtr;
    logic [c_PW-1:0]   r_rdPtr;
    logic [c_CW-1:0]   r_count;
    logic [DEPTH-1:0]  r_valid;

    // Pointers, occupancy and per-entry valid bits; reset discards all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (push) begin
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + c_PW'(1);
            end
            if (pop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + c_PW'(1);
            end
            r_count <= r_count + c_CW'(push) - c_CW'(pop);
        end
    end

    // Storage array; contents are qualified by r_valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

    assign head     = r_mem[r_rdPtr];
    assign count    = r_count;
    assign entValid = r_valid;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entAddr
            assign entAddr[i*REG_AW +: REG_AW] = r_mem[i].waddr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the register-file write port between the writeback
//               stage (priority, zero latency) and a buffered long-latency
//               source, with starvation-forced drains and a pending mask.
//               Optional macro RF_ARB_BYPASS_EN lets a B request go straight
//               to the register file when nothing else wants the port.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [4:0]        a_waddr,
    input  logic [31:0]       a_wdata,
    output logic              a_stall,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [4:0]        b_waddr,
    input  logic [31:0]       b_wdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       pend_mask,
    output logic              fifo_empty
);

    localparam int              c_CW          = $clog2(DEPTH) + 1;
    localparam int              c_SW          = $clog2(STARVE_MAX + 1);
    localparam logic [c_CW-1:0] c_FULL        = c_CW'(DEPTH);
    localparam logic [c_SW-1:0] c_STARVE_LAST = c_SW'(STARVE_MAX - 1);

    logic                     w_aActive;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_bypass;
    rf_wreq_t                 w_head;
    rf_wreq_t                 w_pushData;
    logic [c_CW-1:0]          w_count;
    logic [DEPTH-1:0]         w_entValid;
    logic [DEPTH*REG_AW-1:0]  w_entAddr;
    logic [c_SW-1:0]          r_starveCnt;
    logic                     r_aStall;

    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == c_FULL);
    assign b_ready    = !w_full && !rst;
    assign fifo_empty = w_empty || rst;
    assign a_stall    = r_aStall;

    // Writes to r0 are no-ops, so they leave the port free for the FIFO.
    assign w_aActive  = a_we && (a_waddr != '0) && !r_aStall;

    // r0 results are accepted but never stored; a bypassed result skips the FIFO.
    assign w_push     = b_valid && b_ready && (b_waddr != '0) && !w_bypass;
    assign w_pushData = '{waddr: b_waddr, wdata: b_wdata};

    rf_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pushData (w_pushData),
        .pop      (w_pop),
        .head     (w_head),
        .count    (w_count),
        .entValid (w_entValid),
        .entAddr  (w_entAddr)
    );

    // Grant: writeback first, then FIFO head, then (optionally) direct bypass.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        if (!rst) begin
            if (w_aActive) begin
                rf_we    = 1'b1;
                rf_waddr = a_waddr;
                rf_wdata = a_wdata;
            end else if (!w_empty) begin
                rf_we    = 1'b1;
                rf_waddr = w_head.waddr;
                rf_wdata = w_head.wdata;
                w_pop    = 1'b1;
            end
`ifdef RF_ARB_BYPASS_EN
            else if (b_valid && (b_waddr != '0) && !r_aStall) begin
                rf_we    = 1'b1;
                rf_waddr = b_waddr;
                rf_wdata = b_wdata;
                w_bypass = 1'b1;
            end
`endif
        end
    end

    // Pending mask: OR of the destinations of all buffered entries.
    always_comb begin
        pend_mask = '0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_entValid[i]) begin
                    pend_mask = pend_mask | onehot32(w_entAddr[i*REG_AW +: REG_AW]);
                end
            end
        end
    end

    // Starvation tracking; a one-cycle stall steals the port for the FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCnt <= '0;
            r_aStall    <= 1'b0;
        end else begin
            if (!w_empty && !w_pop) begin
                r_starveCnt <= r_starveCnt + c_SW'(1);
            end else begin
                r_starveCnt <= '0;
            end
            r_aStall <= !w_empty && !w_pop &&
                        ((r_starveCnt == c_STARVE_LAST) || (w_count == c_FULL));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench for rf_write_arbiter: directed scenarios
//               followed by random traffic, checked every cycle against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
`ifdef RF_ARB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        fifo_empty;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_we       (a_we),
        .a_waddr    (a_waddr),
        .a_wdata    (a_wdata),
        .a_stall    (a_stall),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_waddr    (b_waddr),
        .b_wdata    (b_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pend_mask  (pend_mask),
        .fifo_empty (fifo_empty)
    );

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: buffered results as a plain queue of {addr, data}.
    logic [36:0] mQ [$];
    int          mStarve = 0;
    bit          mStall  = 1'b0;

    // Values sampled in the most recent cycle.
    logic        sWe, sStall, sReady;
    logic [4:0]  sAddr;
    logic [31:0] sData, sPend;
    bit          lastStall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample mid-cycle, compare to model, advance over the edge.
    task automatic cyc();
        bit          aAct, expWe, doPop, byp, push, busy, nStall;
        logic [4:0]  expAddr;
        logic [31:0] expData, expPend;
        int          nStarve;
        #2;
        sWe = rf_we; sAddr = rf_waddr; sData = rf_wdata;
        sPend = pend_mask; sStall = a_stall; sReady = b_ready;
        lastStall = sStall;
        if (rst) begin
            check("rst_rf_we", rf_we, 0);
            check("rst_b_ready", b_ready, 0);
            check("rst_pend_mask", pend_mask, 0);
            check("rst_fifo_empty", fifo_empty, 1);
            mQ.delete();
            nStall  = 1'b0;
            nStarve = 0;
        end else begin
            expPend = '0;
            foreach (mQ[i]) expPend = expPend | (32'd1 << mQ[i][36:32]);
            check("a_stall", a_stall, mStall);
            check("b_ready", b_ready, mQ.size() < DEPTH);
            check("fifo_empty", fifo_empty, mQ.size() == 0);
            check("pend_mask", pend_mask, expPend);
            aAct  = a_we && (a_waddr != 0) && !mStall;
            expWe = 1'b0; doPop = 1'b0; byp = 1'b0;
            expAddr = '0; expData = '0;
            if (aAct) begin
                expWe = 1'b1; expAddr = a_waddr; expData = a_wdata;
            end else if (mQ.size() > 0) begin
                expWe = 1'b1; expAddr = mQ[0][36:32]; expData = mQ[0][31:0]; doPop = 1'b1;
            end else if (c_BYP && b_valid && (b_waddr != 0)) begin
                expWe = 1'b1; expAddr = b_waddr; expData = b_wdata; byp = 1'b1;
            end
            check("rf_we", rf_we, expWe);
            if (expWe) begin
                check("rf_waddr", rf_waddr, expAddr);
                check("rf_wdata", rf_wdata, expData);
            end
            check("no_r0_write", rf_we && (rf_waddr == 0), 0);
            push    = b_valid && (mQ.size() < DEPTH) && (b_waddr != 0) && !byp;
            busy    = (mQ.size() > 0) && !doPop;
            nStall  = busy && ((mStarve == STARVE_MAX - 1) || (mQ.size() == DEPTH));
            nStarve = busy ? mStarve + 1 : 0;
            if (doPop) void'(mQ.pop_front());
            if (push)  mQ.push_back({b_waddr, b_wdata});
        end
        @(posedge clk);
        #1;
        mStall  = nStall;
        mStarve = nStarve;
    endtask

    task automatic idle();
        a_we = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
    endtask

    // Continuous writeback traffic; a stalled request is held and re-presented.
    task automatic aCont();
        if (!lastStall) begin
            a_we    = 1'b1;
            a_waddr = 5'($urandom_range(8, 31));
            a_wdata = $urandom;
        end
    endtask

    logic [4:0] drained [$];
    logic [4:0] fillAddr [4];
    int         stallCnt, stallPos;
    logic [4:0] stallAddr;
    bit         prevDrain;

    initial begin
        // Reset held two cycles with a B request pending.
        rst = 1'b1;
        idle();
        b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'h1234_5678;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        check("b_ready_after_reset", sReady, 1);
        idle();
        repeat (3) cyc();

        // Single B write to r5 with A idle.
        b_valid = 1'b1; b_waddr = 5'd5; b_wdata = 32'hDEAD_BEEF;
        cyc();
`ifdef RF_ARB_BYPASS_EN
        check("r5_bypass_we", sWe, 1);
        check("r5_bypass_addr", sAddr, 5);
        check("r5_bypass_pend", sPend, 0);
        idle();
        cyc();
        check("r5_bypass_pend_after", sPend, 0);
`else
        check("r5_cycle_k_we", sWe, 0);
        idle();
        cyc();
        check("r5_pend_k1", sPend, 32'h20);
        check("r5_we_k1", sWe, 1);
        check("r5_addr_k1", sAddr, 5);
        check("r5_data_k1", sData, 32'hDEAD_BEEF);
        cyc();
        check("r5_pend_k2", sPend, 0);
`endif
        repeat (2) cyc();

        // r3 buffered behind an A write, then A writes only r0.
        a_we = 1'b1; a_waddr = 5'd1; a_wdata = 32'h1111_1111;
        b_valid = 1'b1; b_waddr = 5'd3; b_wdata = 32'h3333_3333;
        cyc();
        b_valid = 1'b0;
        a_waddr = 5'd0; a_wdata = 32'hBAD0_BAD0;
        cyc();
        check("r0_drain_we", sWe, 1);
        check("r0_drain_addr", sAddr, 3);
        repeat (3) cyc();
        idle();
        repeat (2) cyc();

        // Starvation: one r7 entry under continuous A traffic.
        aCont();
        b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'h7777_7777;
        cyc();
        b_valid = 1'b0;
        stallCnt = 0; stallPos = 0; stallAddr = '0;
        for (int j = 1; j <= 12; j++) begin
            aCont();
            cyc();
            if (sStall) begin
                stallCnt++;
                stallPos  = j;
                stallAddr = sAddr;
            end
        end
        check("starve_pulse_count", stallCnt, 1);
        check("starve_pulse_pos", stallPos, 9);
        check("starve_drain_addr", stallAddr, 7);
        idle();
        repeat (3) cyc();

        // Fill to DEPTH with r1, r1, r2, r3 under continuous A traffic.
        fillAddr[0] = 5'd1; fillAddr[1] = 5'd1; fillAddr[2] = 5'd2; fillAddr[3] = 5'd3;
        drained.delete();
        prevDrain = 1'b0;
        for (int j = 1; j <= 45; j++) begin
            aCont();
            if (j <= 4) begin
                b_valid = 1'b1; b_waddr = fillAddr[j-1]; b_wdata = $urandom;
            end else begin
                b_valid = 1'b0;
            end
            cyc();
            if (j == 5) begin
                check("fill_ready_low", sReady, 0);
                check("fill_pend_r1", sPend[1], 1);
            end
            if (j == 6) check("fill_stall_next", sStall, 1);
            if (prevDrain) check("fill_pend_r1_hold", sPend[1], drained.size() < 2);
            prevDrain = sStall;
            if (sStall) drained.push_back(sAddr);
        end
        check("fill_drain_count", drained.size(), 4);
        for (int i = 0; i < drained.size() && i < 4; i++) begin
            check("fill_drain_order", drained[i], fillAddr[i]);
        end
        idle();
        repeat (3) cyc();

        // Random traffic, including r0 targets, pointer wraps and a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            rst = (i == 200);
            if (!lastStall) begin
                a_we    = ($urandom_range(0, 99) < 75);
                a_waddr = 5'($urandom_range(0, 31));
                a_wdata = $urandom;
            end
            b_valid = ($urandom_range(0, 99) < 50);
            b_waddr = 5'($urandom_range(0, 31));
            b_wdata = $urandom;
            cyc();
        end
        rst = 1'b0;
        idle();
        repeat (12) cyc();
        check("final_empty", fifo_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (rf_we / rf_waddr / rf_wdata) between the pipeline writeback stage and a long-latency result source (multi-cycle unit, late load return). Writeback has priority and a zero-latency path. Long-latency results are buffered in a small FIFO and drained into free writeback slots. The block also exports a pending-destination mask so decode can stall on registers still owed by the long-latency path.

## Interface
Parameters:
- DEPTH, 4, long-latency FIFO entries; power of two, ≥2
- STARVE_MAX, 8, consecutive non-draining cycles with a non-empty FIFO before a forced drain; ≥1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- a_we  in  1  writeback write request
- a_waddr  in  5  writeback destination
- a_wdata  in  32  writeback data
- a_stall  out  1  registered; pipeline must hold its WB stage this cycle and re-present the request
- b_valid  in  1  long-latency result valid
- b_ready  out  1  FIFO can accept
- b_waddr  in  5  long-latency destination
- b_wdata  in  32  long-latency data
- rf_we  out  1  to register file
- rf_waddr  out  5  to register file
- rf_wdata  out  32  to register file
- pend_mask  out  32  bit r set while any FIFO entry targets register r
- fifo_empty  out  1  no buffered entries

## Operation
- The clock is clk. Reset is synchronous and active-high on rst.
- a_active = a_we && a_waddr != 0 && !a_stall. A write to r0 counts as idle and frees the slot.
- Grant each cycle, combinational:
  - If a_active: drive A onto rf_*.
  - Else if the FIFO is non-empty: drive the head onto rf_* and pop at the edge.
  - Else: rf_we = 0.
- The block never issues a write to r0.
- Enqueue when b_valid && b_ready. b_ready = !full && !rst.
  - A request with b_waddr == 0 is accepted and discarded: no entry, no pend bit.
- Push and pop in the same cycle are legal. Count is unchanged, and the pointers wrap mod DEPTH.
- pend_mask = OR over valid entries of onehot(waddr). Duplicate destinations are allowed. A bit clears only when the last entry for that register pops.
- Starvation counter starve_cnt:
  - Increments when the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - a_stall next = non-empty && no pop this cycle && (starve_cnt == STARVE_MAX-1 || count == DEPTH).
  - a_stall is high for exactly one cycle. In that cycle a_we is ignored, the head drains, and starve_cnt clears.
- Ordering is not resolved here. Decode must stall any instruction whose sources or destination hit pend_mask, which prevents WAW/RAW against buffered results.
- Reset values: count 0, pointers 0, starve_cnt 0, a_stall 0.
  - While rst is high: rf_we 0, b_ready 0, pend_mask 0, fifo_empty 1.
  - Reset mid-operation discards all buffered entries with no RF write.

## Timing
- A path: zero latency. A request in cycle k is written at the edge ending cycle k, unless a_stall is high in cycle k.
- B path: accepted at edge k.
  - pend bit is visible in cycle k+1.
  - Earliest RF write is at the edge ending cycle k+1.
- Maximum B wait under continuous A traffic: STARVE_MAX+1 cycles after reaching the head.
- Full FIFO with A busy: a_stall is asserted the cycle after full is reached with no pop.
- b_ready is combinational from registered count only. It never depends on b_valid.

## Configuration
- RF_ARB_BYPASS_EN defined:
  - If the FIFO is empty, A is not active and a_stall is low, a valid B request goes straight to rf_* in the same cycle and is not enqueued.
  - No pend bit is set, and b_ready is still asserted.
- RF_ARB_BYPASS_EN undefined: every B request goes through the FIFO (minimum one-cycle latency).

## Structure
- Package rf_arb_pkg holds:
  - REG_AW = 5, REG_DW = 32.
  - typedef rf_wreq_t {waddr, wdata}.
  - function onehot32.
- Sub-module rf_arb_fifo: a DEPTH-entry circular buffer of rf_wreq_t.
  - Ports: push, pop, head, count, and per-entry valid/addr outputs for the pend_mask reduction.
- The arbiter owns grant logic, the starvation counter, a_stall and bypass.

## Test plan
- Reset with b_valid=1 pending: rst held 2 cycles. During reset rf_we=0, b_ready=0, pend_mask=0. b_ready=1 in the first cycle after release.
- A idle, one B write to r5 = 0xDEADBEEF at edge k:
  - pend_mask = 0x20 in cycle k+1.
  - RF write r5 at edge k+1.
  - pend_mask = 0 in cycle k+2.
  - With bypass: written at edge k, pend_mask stays 0.
- A writes to r0 each cycle while FIFO holds r3: r3 drains on the first cycle and rf_waddr never equals 0.
- Continuous A writes with one B entry (r7) and STARVE_MAX=8: a_stall pulses once 8 cycles after enqueue, r7 is written in that cycle, and the stalled A write lands the next cycle.
- Fill DEPTH=4 with r1, r1, r2, r3 under continuous A:
  - b_ready drops at full.
  - a_stall is asserted the next cycle.
  - pend bit 1 stays set until the second r1 entry pops.
  - Entries drain in FIFO order.
- Push and pop in the same cycle at count=DEPTH-1 across a pointer wrap: count is unchanged and data integrity holds over 20 random entries.
